// File: rtl/icache_if.sv
// Fetch and memory-controller signal bundle for the instruction cache.
// The cache is the slave side; the fetch unit and memory controller together act as master.
interface icache_if;
    // Every *_En signal is a one-cycle pulse with no back-pressure: a payload is
    // valid only while its En is high, and each pulse is one event. The cache
    // raises at most one oMC_En until iMC_En returns, and the fetcher issues no
    // new iIF_En until oIF_En answers.
    logic        iIF_En;
    logic [31:0] iIF_Pc;
    logic        iClr;
    logic        oIF_En;
    logic [31:0] oIF_Ins;
    logic        oMC_En;
    logic [31:0] oMC_Pc;
    logic        iMC_En;
    logic [31:0] iMC_Ins;

    modport master (
        output iIF_En, iIF_Pc, iClr, iMC_En, iMC_Ins,
        input  oIF_En, oIF_Ins, oMC_En, oMC_Pc
    );

    modport slave (
        input  iIF_En, iIF_Pc, iClr, iMC_En, iMC_Ins,
        output oIF_En, oIF_Ins, oMC_En, oMC_Pc
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with one-word lines and a single outstanding fill.
// Defining IC_PREFETCH_EN adds a next-line prefetch after each demand fill.
module icache #(
    parameter int IDX_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    icache_if.slave    bus,
    output logic [1:0] dbg_state
);
    localparam int NL    = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

`ifdef IC_PREFETCH_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MISS = 2'd1, PREF = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MISS = 2'd1} state_t;
`endif

    state_t state_q, state_n;

    logic [31:0]      data_mem [NL];
    logic [TAG_W-1:0] tag_mem  [NL];
    logic [NL-1:0]    valid_q;

    logic [31:0] req_q, req_n;
    logic        pend_q, pend_n;
    logic [31:0] pend_pc_q, pend_pc_n;
    logic        drop_q, drop_n;
    logic        oif_en_q, oif_en_n;
    logic [31:0] oif_ins_q, oif_ins_n;
    logic        omc_en_q, omc_en_n;
    logic [31:0] omc_pc_q, omc_pc_n;

    logic             we;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      lk_pc;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_hit;
    logic             unused_bits;

    // A replayed pending request takes priority over the live fetch port.
    assign lk_pc  = pend_q ? pend_pc_q : bus.iIF_Pc;
    assign lk_idx = lk_pc[IDX_W+1:2];
    assign lk_hit = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_pc[31:IDX_W+2]);
    assign wr_idx = req_q[IDX_W+1:2];
    assign unused_bits = &{1'b0, lk_pc[1:0], req_q[1:0]};

`ifdef IC_PREFETCH_EN
    logic [31:0]      pf_pc;
    logic [IDX_W-1:0] pf_idx;
    logic             pf_hit;

    assign pf_pc  = req_q + 32'd4;
    assign pf_idx = pf_pc[IDX_W+1:2];
    assign pf_hit = valid_q[pf_idx] && (tag_mem[pf_idx] == pf_pc[31:IDX_W+2]);
`endif

    assign bus.oIF_En  = oif_en_q;
    assign bus.oIF_Ins = oif_ins_q;
    assign bus.oMC_En  = omc_en_q;
    assign bus.oMC_Pc  = omc_pc_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_n   = state_q;
        req_n     = req_q;
        pend_n    = pend_q;
        pend_pc_n = pend_pc_q;
        drop_n    = drop_q;
        oif_en_n  = 1'b0;
        oif_ins_n = oif_ins_q;
        omc_en_n  = 1'b0;
        omc_pc_n  = omc_pc_q;
        we        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.iClr) begin
                    pend_n = 1'b0;
                end else if (pend_q || bus.iIF_En) begin
                    pend_n = 1'b0;
                    if (lk_hit) begin
                        oif_en_n  = 1'b1;
                        oif_ins_n = data_mem[lk_idx];
                    end else begin
                        omc_en_n = 1'b1;
                        omc_pc_n = {lk_pc[31:2], 2'b00};
                        req_n    = {lk_pc[31:2], 2'b00};
                        drop_n   = 1'b0;
                        state_n  = MISS;
                    end
                end
            end
            MISS: begin
                if (bus.iClr) drop_n = 1'b1;
                if (bus.iMC_En) begin
                    we        = 1'b1;
                    oif_en_n  = !(drop_q || bus.iClr);
                    oif_ins_n = bus.iMC_Ins;
                    drop_n    = 1'b0;
                    state_n   = IDLE;
`ifdef IC_PREFETCH_EN
                    if (!pf_hit) begin
                        omc_en_n = 1'b1;
                        omc_pc_n = pf_pc;
                        req_n    = pf_pc;
                        state_n  = PREF;
                    end
`endif
                end
            end
`ifdef IC_PREFETCH_EN
            PREF: begin
                if (bus.iClr) begin
                    pend_n = 1'b0;
                end else if (bus.iIF_En && !pend_q) begin
                    pend_n    = 1'b1;
                    pend_pc_n = bus.iIF_Pc;
                end
                if (bus.iMC_En) begin
                    we      = 1'b1;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            req_q     <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            drop_q    <= 1'b0;
            oif_en_q  <= 1'b0;
            oif_ins_q <= '0;
            omc_en_q  <= 1'b0;
            omc_pc_q  <= '0;
        end else if (en) begin
            state_q   <= state_n;
            req_q     <= req_n;
            pend_q    <= pend_n;
            pend_pc_q <= pend_pc_n;
            drop_q    <= drop_n;
            oif_en_q  <= oif_en_n;
            oif_ins_q <= oif_ins_n;
            omc_en_q  <= omc_en_n;
            omc_pc_q  <= omc_pc_n;
            if (we) valid_q[wr_idx] <= 1'b1;
        end
    end

    // Line storage has no reset; the valid bits alone qualify its contents.
    always_ff @(posedge clk) begin
        if (!rst && en && we) begin
            data_mem[wr_idx] <= bus.iMC_Ins;
            tag_mem[wr_idx]  <= req_q[31:IDX_W+2];
        end
    end
endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache; the prefetch scenario builds when IC_PREFETCH_EN is defined.
module tb_icache;
  localparam logic [31:0] S_IDLE = 32'd0;
  localparam logic [31:0] S_MISS = 32'd1;
  localparam logic [31:0] S_PREF = 32'd2;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] dbg_state;
  int         total;
  int         bad;
  int         omc_cnt;
  int         oif_cnt;
  int         oif_mark;
  logic [31:0] exp_q[$];

  icache_if bus ();

  icache #(.IDX_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      omc_cnt = 0;
      oif_cnt = 0;
    end else begin
      if (bus.oMC_En) omc_cnt = omc_cnt + 1;
      if (bus.oIF_En) oif_cnt = oif_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change on negedge, outputs are sampled on the following negedge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] pc);
    bus.iIF_En = 1'b1;
    bus.iIF_Pc = pc;
    @(negedge clk);
    bus.iIF_En = 1'b0;
  endtask

  task automatic fill(input logic [31:0] ins);
    bus.iMC_En  = 1'b1;
    bus.iMC_Ins = ins;
    @(negedge clk);
    bus.iMC_En  = 1'b0;
  endtask

  task automatic clr();
    bus.iClr = 1'b1;
    @(negedge clk);
    bus.iClr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // scoreboard: the next returned instruction must match the head of exp_q
  task automatic expect_hit(input string tag);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    check({tag, "_en"}, {31'd0, bus.oIF_En}, 32'd1);
    check({tag, "_ins"}, bus.oIF_Ins, e);
  endtask

  task automatic expect_miss(input string tag, input logic [31:0] pc);
    check({tag, "_mc_en"}, {31'd0, bus.oMC_En}, 32'd1);
    check({tag, "_mc_pc"}, bus.oMC_Pc, pc);
    check({tag, "_if_en"}, {31'd0, bus.oIF_En}, 32'd0);
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, "_if_en"}, {31'd0, bus.oIF_En}, 32'd0);
    check({tag, "_mc_en"}, {31'd0, bus.oMC_En}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    en = 1'b1;
    bus.iIF_En = 1'b0;
    bus.iIF_Pc = '0;
    bus.iClr = 1'b0;
    bus.iMC_En = 1'b0;
    bus.iMC_Ins = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_if_en", {31'd0, bus.oIF_En}, 32'd0);
    check("rst_mc_en", {31'd0, bus.oMC_En}, 32'd0);
    check("rst_if_ins", bus.oIF_Ins, 32'd0);
    check("rst_mc_pc", bus.oMC_Pc, 32'd0);
    check("rst_state", {30'd0, dbg_state}, S_IDLE);

`ifndef IC_PREFETCH_EN
    // first miss and fill
    fetch(32'h100);
    expect_miss("miss100", 32'h100);
    check("miss100_state", {30'd0, dbg_state}, S_MISS);
    tick();
    check("mc_pulse_one_cycle", {31'd0, bus.oMC_En}, 32'd0);
    exp_q.push_back(32'h00500093);
    fill(32'h00500093);
    expect_hit("fill100");
    check("fill100_no_pf", {31'd0, bus.oMC_En}, 32'd0);
    check("fill100_state", {30'd0, dbg_state}, S_IDLE);
    tick();
    check("if_pulse_one_cycle", {31'd0, bus.oIF_En}, 32'd0);

    // hits, low address bits ignored
    exp_q.push_back(32'h00500093);
    fetch(32'h100);
    expect_hit("hit100");
    check("hit100_no_mc", {31'd0, bus.oMC_En}, 32'd0);
    exp_q.push_back(32'h00500093);
    fetch(32'h102);
    expect_hit("hit102");
    check("hit102_no_mc", {31'd0, bus.oMC_En}, 32'd0);

    // conflict on index 0
    fetch(32'h200);
    expect_miss("miss200", 32'h200);
    exp_q.push_back(32'h22222222);
    fill(32'h22222222);
    expect_hit("fill200");
    fetch(32'h100);
    expect_miss("remiss100", 32'h100);
    exp_q.push_back(32'h00500093);
    fill(32'h00500093);
    expect_hit("refill100");

    // flush during a fill: still written, response suppressed
    fetch(32'h300);
    expect_miss("miss300", 32'h300);
    clr();
    fill(32'h33333333);
    expect_quiet("clr_fill300");
    check("clr_fill300_state", {30'd0, dbg_state}, S_IDLE);
    exp_q.push_back(32'h33333333);
    fetch(32'h300);
    expect_hit("hit300");

    // flush together with a request in IDLE drops it
    bus.iClr = 1'b1;
    fetch(32'h300);
    bus.iClr = 1'b0;
    expect_quiet("clr_with_req");

    // global enable freezes outputs and ignores inputs
    exp_q.push_back(32'h33333333);
    fetch(32'h300);
    expect_hit("hit300_b");
    en = 1'b0;
    tick();
    check("en_low_hold", {31'd0, bus.oIF_En}, 32'd1);
    en = 1'b1;
    tick();
    check("en_high_release", {31'd0, bus.oIF_En}, 32'd0);
    en = 1'b0;
    fetch(32'h500);
    en = 1'b1;
    tick();
    expect_quiet("en_low_req");
    check("en_low_state", {30'd0, dbg_state}, S_IDLE);

    // stray fill in IDLE is ignored and writes nothing
    fill(32'hDEADBEEF);
    expect_quiet("stray_fill");
    exp_q.push_back(32'h33333333);
    fetch(32'h300);
    expect_hit("after_stray");

    // requests during MISS are ignored
    fetch(32'h500);
    expect_miss("miss500", 32'h500);
    fetch(32'h600);
    expect_quiet("req_in_miss");
    exp_q.push_back(32'h55555555);
    fill(32'h55555555);
    expect_hit("fill500");
    fetch(32'h600);
    expect_miss("miss600", 32'h600);
    exp_q.push_back(32'h66666666);
    fill(32'h66666666);
    expect_hit("fill600");

    // reset in the middle of a fill
    fetch(32'h700);
    expect_miss("miss700", 32'h700);
    do_reset();
    check("midrst_state", {30'd0, dbg_state}, S_IDLE);
    fill(32'h77777777);
    expect_quiet("fill_after_rst");
    fetch(32'h700);
    expect_miss("miss700_again", 32'h700);
    exp_q.push_back(32'h77777777);
    fill(32'h77777777);
    expect_hit("fill700");
    fetch(32'h100);
    expect_miss("miss100_after_rst", 32'h100);
    exp_q.push_back(32'h00500093);
    fill(32'h00500093);
    expect_hit("fill100_after_rst");
`else
    // demand fill followed by next-line prefetch
    fetch(32'h400);
    expect_miss("miss400", 32'h400);
    exp_q.push_back(32'h44444444);
    fill(32'h44444444);
    expect_hit("fill400");
    check("pf404_mc_en", {31'd0, bus.oMC_En}, 32'd1);
    check("pf404_mc_pc", bus.oMC_Pc, 32'h404);
    check("pf404_state", {30'd0, dbg_state}, S_PREF);
    fetch(32'h404);
    expect_quiet("req_in_pref");
    fill(32'h45454545);
    expect_quiet("pf404_done");
    check("pf404_done_state", {30'd0, dbg_state}, S_IDLE);
    tick();
    exp_q.push_back(32'h45454545);
    expect_hit("replay404");
    check("replay404_no_mc", {31'd0, bus.oMC_En}, 32'd0);
    check("mc_pulses_total", omc_cnt, 32'd2);

    // prefetch address wraps to zero
    fetch(32'hFFFFFFFC);
    expect_miss("missFFC", 32'hFFFFFFFC);
    exp_q.push_back(32'hAAAAAAAA);
    fill(32'hAAAAAAAA);
    expect_hit("fillFFC");
    check("pf0_mc_en", {31'd0, bus.oMC_En}, 32'd1);
    check("pf0_mc_pc", bus.oMC_Pc, 32'h0);
    fill(32'hBBBBBBBB);
    exp_q.push_back(32'hBBBBBBBB);
    fetch(32'h0);
    expect_hit("hit0");

    // flush in PREF drops the pending request, prefetch still lands
    fetch(32'h800);
    expect_miss("miss800", 32'h800);
    exp_q.push_back(32'h88888888);
    fill(32'h88888888);
    expect_hit("fill800");
    check("pf804_mc_pc", bus.oMC_Pc, 32'h804);
    fetch(32'h804);
    clr();
    oif_mark = oif_cnt;
    fill(32'h89898989);
    repeat (2) tick();
    check("pref_clr_no_resp", oif_cnt, oif_mark);
    check("pref_clr_state", {30'd0, dbg_state}, S_IDLE);
    exp_q.push_back(32'h89898989);
    fetch(32'h804);
    expect_hit("hit804");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter IDX_W, default 6, index width; the cache holds 2^IDX_W direct-mapped one-word lines.
REQ-002 clk  input  1  clock, all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  global enable; when low, no register or array updates occur and all outputs hold.
REQ-005 iIF_En  input  1  fetch request pulse from instruction fetch.
REQ-006 iIF_Pc  input  32  fetch address; bits [1:0] ignored.
REQ-007 iClr  input  1  pipeline flush; discards the outstanding fetch.
REQ-008 oIF_En  output  1  one-cycle pulse, instruction valid.
REQ-009 oIF_Ins  output  32  returned instruction, valid while oIF_En is high.
REQ-010 oMC_En  output  1  one-cycle pulse, line fill request to the memory controller.
REQ-011 oMC_Pc  output  32  fill address, word aligned, stable from the oMC_En cycle until iMC_En.
REQ-012 iMC_En  input  1  fill-complete pulse from the memory controller.
REQ-013 iMC_Ins  input  32  fill data, valid while iMC_En is high.

Function
REQ-014 index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; a hit requires valid[index] set and tag[index] equal.
REQ-015 States: IDLE, MISS, PREF (PREF exists only when the configuration macro is defined).
REQ-016 IDLE with iIF_En and a hit: oIF_En=1 and oIF_Ins=data on the next cycle; latency 1; state stays IDLE.
REQ-017 IDLE with iIF_En and a miss: oMC_En=1 and oMC_Pc={pc[31:2],2'b00} on the next cycle; state goes to MISS; the demand address is latched.
REQ-018 MISS with iMC_En: the line is written (data, tag, valid=1); oIF_En=1 with oIF_Ins=iMC_Ins on the next cycle; state goes to IDLE, or to PREF per REQ-026.
REQ-019 At most one fill is outstanding; oMC_En is never asserted again before iMC_En for the previous fill.
REQ-020 iIF_En in MISS is ignored, because the fetcher holds off until oIF_En.
REQ-021 iClr in MISS: the fill still completes and is written; the oIF_En for that fill is suppressed.
REQ-022 iClr together with iIF_En in IDLE: the clear wins; the request is dropped and no response is produced.
REQ-023 iMC_En outside MISS or PREF is ignored.
REQ-024 oIF_En and oMC_En are registered and never high for more than one enabled cycle per event.

Reset
REQ-025 On rst: all valid bits cleared; state IDLE; oIF_En=0, oMC_En=0, oIF_Ins=0, oMC_Pc=0; the pending and drop flags are cleared; rst mid-fill abandons the fill and a later iMC_En is ignored.

Configuration
REQ-026 Macro IC_PREFETCH_EN: when defined, a demand fill completing in MISS is followed by a lookup of line pc+4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000); if that line misses, oMC_En for pc+4 is issued on the cycle after iMC_En and the state goes to PREF; if it hits, the state goes to IDLE.
REQ-027 In PREF, a single iIF_En is latched into a pending register, and further requests are ignored.
REQ-028 In PREF, iMC_En writes the line and moves the state to IDLE; a latched pending request is replayed as an IDLE request on the following cycle and hits if it matches the prefetched line.
REQ-029 In PREF, iClr clears the pending request; the prefetch still completes.
REQ-030 When IC_PREFETCH_EN is undefined, no PREF state exists, MISS always returns to IDLE, and no speculative oMC_En is issued.

Verification
REQ-031 After reset, iIF_En pc=0x100 -> oMC_En next cycle, oMC_Pc=0x100; iMC_En with 0x00500093 -> oIF_En one cycle later with oIF_Ins=0x00500093.
REQ-032 Repeat pc=0x100 -> oIF_En on the next cycle with no oMC_En; pc=0x102 behaves identically.
REQ-033 With IDX_W=6, fill 0x100 then request 0x200 (same index, different tag) -> miss with oMC_Pc=0x200; 0x100 then misses again.
REQ-034 Miss on 0x300, iClr one cycle later, then iMC_En -> no oIF_En; a subsequent 0x300 request hits.
REQ-035 IC_PREFETCH_EN: miss 0x400 completes -> oMC_Pc=0x404 issued; iIF_En 0x404 during PREF -> oIF_En with the prefetched data and exactly two oMC_En pulses in total; miss 0xFFFFFFFC -> prefetch oMC_Pc=0x00000000.
REQ-036 Assert rst while in MISS, then inject iMC_En -> no oIF_En and no array write; 0x100 misses afterwards.
